// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: arbitrates one-cycle game events by priority and steps a
// fixed per-effect note pattern, timed in VGA frames, into a shared tone generator.
module sound_sequencer #(
    parameter int PERIOD_W    = 8,
    parameter int FRAME_SCALE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vsync,
    input  logic                failure,
    input  logic                success,
    input  logic                eat,
    input  logic                tick,
    input  logic                mute,
    output logic                tone_en,
    output logic [PERIOD_W-1:0] tone_period,
    output logic                busy,
    output logic [1:0]          active_sfx
);
    typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t              state_r, state_nx_s;
    logic [1:0]          step_r, step_nx_s;
    logic [5:0]          count_r, count_nx_s;
    logic [PERIOD_W-1:0] period_r, period_nx_s;
    logic                busy_r, busy_nx_s;
    logic [1:0]          sfx_r, sfx_nx_s;
    logic                en_r, en_nx_s;
    logic                vsync_r;
    logic                edge_s, ev_any_s, accept_s;
    logic [1:0]          win_s;

    function automatic logic [7:0] rom_period(input logic [1:0] sfx, input logic [1:0] step);
        logic [7:0] p;
        case ({sfx, step})
            4'b00_00: p = 8'd119;
            4'b01_00: p = 8'd159;
            4'b01_01: p = 8'd119;
            4'b10_00: p = 8'd239;
            4'b10_01: p = 8'd190;
            4'b10_10: p = 8'd159;
            4'b10_11: p = 8'd119;
            4'b11_00: p = 8'd159;
            4'b11_01: p = 8'd190;
            4'b11_10: p = 8'd213;
            4'b11_11: p = 8'd239;
            default:  p = 8'd0;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] rom_units(input logic [1:0] sfx, input logic [1:0] step);
        logic [3:0] u;
        case ({sfx, step})
            4'b00_00: u = 4'd1;
            4'b01_00: u = 4'd3;
            4'b01_01: u = 4'd3;
            4'b10_00: u = 4'd4;
            4'b10_01: u = 4'd4;
            4'b10_10: u = 4'd4;
            4'b10_11: u = 4'd8;
            4'b11_00: u = 4'd6;
            4'b11_01: u = 4'd6;
            4'b11_10: u = 4'd6;
            4'b11_11: u = 4'd12;
            default:  u = 4'd1;
        endcase
        return u;
    endfunction

    function automatic logic [1:0] rom_last(input logic [1:0] sfx);
        logic [1:0] l;
        case (sfx)
            2'd0:    l = 2'd0;
            2'd1:    l = 2'd1;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    // Step duration in frame edges; 12 units * scale 4 still fits in 6 bits.
    function automatic logic [5:0] frames(input logic [3:0] units);
        return 6'(units) * 6'(FRAME_SCALE);
    endfunction

    // Frame-edge detect and priority arbitration; equal priority re-triggers.
    always_comb begin
        edge_s   = vsync & ~vsync_r;
        ev_any_s = failure | success | eat | tick;
        if (failure) begin
            win_s = 2'd3;
        end else if (success) begin
            win_s = 2'd2;
        end else if (eat) begin
            win_s = 2'd1;
        end else begin
            win_s = 2'd0;
        end
        accept_s = ev_any_s & ((state_r == IDLE) | (win_s >= sfx_r));
    end

    // Next-state logic: an accepted event overrides any frame edge in the same cycle.
    always_comb begin
        state_nx_s  = state_r;
        step_nx_s   = step_r;
        count_nx_s  = count_r;
        period_nx_s = period_r;
        busy_nx_s   = busy_r;
        sfx_nx_s    = sfx_r;
        if (accept_s) begin
            state_nx_s  = PLAY;
            step_nx_s   = 2'd0;
            count_nx_s  = frames(rom_units(win_s, 2'd0));
            period_nx_s = PERIOD_W'(rom_period(win_s, 2'd0));
            busy_nx_s   = 1'b1;
            sfx_nx_s    = win_s;
        end else if ((state_r == PLAY) && edge_s) begin
            if (count_r == 6'd1) begin
                if (step_r == rom_last(sfx_r)) begin
                    state_nx_s = IDLE;
                    busy_nx_s  = 1'b0;
                end else begin
                    step_nx_s   = step_r + 2'd1;
                    count_nx_s  = frames(rom_units(sfx_r, step_r + 2'd1));
                    period_nx_s = PERIOD_W'(rom_period(sfx_r, step_r + 2'd1));
                end
            end else begin
                count_nx_s = count_r - 6'd1;
            end
        end else begin
            state_nx_s = state_r;
        end
        en_nx_s = (state_nx_s == PLAY) & ~mute;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            step_r   <= 2'd0;
            count_r  <= 6'd0;
            period_r <= '0;
            busy_r   <= 1'b0;
            sfx_r    <= 2'd0;
            en_r     <= 1'b0;
            vsync_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            step_r   <= step_nx_s;
            count_r  <= count_nx_s;
            period_r <= period_nx_s;
            busy_r   <= busy_nx_s;
            sfx_r    <= sfx_nx_s;
            en_r     <= en_nx_s;
            vsync_r  <= vsync;
        end
    end

    assign tone_en     = en_r;
    assign tone_period = period_r;
    assign busy        = busy_r;
    assign active_sfx  = sfx_r;
endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: vector table, directed corner sequences and
// randomized traffic against a queue-based pattern model.
module tb_sound_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0, failure = 1'b0, success = 1'b0, eat = 1'b0, tick = 1'b0, mute = 1'b0;
    logic       en1, busy1, en2, busy2;
    logic [7:0] per1, per2;
    logic [1:0] sfx1, sfx2;

    int n_checks = 0;
    int n_err    = 0;

    sound_sequencer #(.PERIOD_W(8), .FRAME_SCALE(1)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .failure(failure), .success(success),
        .eat(eat), .tick(tick), .mute(mute), .tone_en(en1), .tone_period(per1),
        .busy(busy1), .active_sfx(sfx1)
    );

    sound_sequencer #(.PERIOD_W(8), .FRAME_SCALE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .failure(failure), .success(success),
        .eat(eat), .tick(tick), .mute(mute), .tone_en(en2), .tone_period(per2),
        .busy(busy2), .active_sfx(sfx2)
    );

    always #5 clk = ~clk;

    // Reference model: pending notes of the current effect kept as a queue.
    typedef struct { int period; int units; } note_t;
    note_t m_q[$];
    int    m_left, m_period, m_sfx;
    bit    m_busy, m_en, m_vq;

    function automatic void m_reset();
        m_q.delete();
        m_left = 0; m_period = 0; m_sfx = 0; m_busy = 0; m_en = 0; m_vq = 0;
    endfunction

    function automatic void m_load(int sfx);
        m_q.delete();
        case (sfx)
            3: begin m_q.push_back('{159, 6}); m_q.push_back('{190, 6});
                     m_q.push_back('{213, 6}); m_q.push_back('{239, 12}); end
            2: begin m_q.push_back('{239, 4}); m_q.push_back('{190, 4});
                     m_q.push_back('{159, 4}); m_q.push_back('{119, 8}); end
            1: begin m_q.push_back('{159, 3}); m_q.push_back('{119, 3}); end
            default: m_q.push_back('{119, 1});
        endcase
    endfunction

    function automatic void m_update();
        bit    fedge;
        int    win;
        note_t n;
        fedge = vsync && !m_vq;
        m_vq  = vsync;
        win   = failure ? 3 : success ? 2 : eat ? 1 : tick ? 0 : -1;
        if (win >= 0 && (!m_busy || win >= m_sfx)) begin
            m_load(win);
            n = m_q.pop_front();
            m_period = n.period; m_left = n.units; m_busy = 1; m_sfx = win;
        end else if (m_busy && fedge) begin
            m_left--;
            if (m_left == 0) begin
                if (m_q.size() == 0) m_busy = 0;
                else begin
                    n = m_q.pop_front();
                    m_period = n.period; m_left = n.units;
                end
            end
        end
        m_en = m_busy && !mute;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) m_reset(); else m_update();
        #1;
    endtask

    task automatic frame();
        vsync = 1'b1; cyc();
        vsync = 1'b0; cyc();
    endtask

    task automatic pulse(input int which);
        failure = (which == 3); success = (which == 2); eat = (which == 1); tick = (which == 0);
        cyc();
        {failure, success, eat, tick} = 4'b0000;
    endtask

    task automatic do_reset();
        {vsync, failure, success, eat, tick, mute} = 6'b000000;
        rst_n = 1'b0;
        m_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic chk4(string name, logic e, logic [7:0] p, logic b, logic [1:0] s);
        chk({name, ".en"}, 32'(en1), 32'(e));
        chk({name, ".period"}, 32'(per1), 32'(p));
        chk({name, ".busy"}, 32'(busy1), 32'(b));
        chk({name, ".sfx"}, 32'(sfx1), 32'(s));
    endtask

    typedef struct {
        logic vs, fl, su, ea, ti, mu;
        logic e; logic [7:0] p; logic b; logic [1:0] s;
    } vec_t;
    vec_t vt[18];

    initial begin
        vt[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd1};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd1};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd1};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd1};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd1};
        vt[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd119,1'b1,2'd1};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'd119,1'b1,2'd1};
        vt[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'd119,1'b1,2'd1};
        vt[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd119,1'b1,2'd1};
        vt[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd119,1'b1,2'd1};
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd119,1'b1,2'd1};
        vt[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,8'd119,1'b0,2'd1};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,8'd119,1'b1,2'd0};
        vt[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,8'd119,1'b0,2'd0};
        vt[14] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,8'd159,1'b1,2'd3};
        vt[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd3};
        vt[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd3};
        vt[17] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,8'd159,1'b1,2'd3};

        do_reset();
        chk4("reset", 1'b0, 8'd0, 1'b0, 2'd0);
        repeat (5) cyc();

        for (int i = 0; i < 18; i++) begin
            vsync = vt[i].vs; failure = vt[i].fl; success = vt[i].su;
            eat = vt[i].ea; tick = vt[i].ti; mute = vt[i].mu;
            cyc();
            chk4($sformatf("vec%0d", i), vt[i].e, vt[i].p, vt[i].b, vt[i].s);
        end
        {vsync, failure, success, eat, tick, mute} = 6'b000000;

        // FRAME_SCALE=2 tick lasts two frame edges
        do_reset();
        pulse(0);
        chk("scale2.start_en", 32'(en2), 32'd1);
        chk("scale2.start_per", 32'(per2), 32'd119);
        frame();
        chk("scale2.after1_en", 32'(en2), 32'd1);
        chk("scale1.after1_en", 32'(en1), 32'd0);
        frame();
        chk("scale2.after2_en", 32'(en2), 32'd0);
        chk("scale2.after2_busy", 32'(busy2), 32'd0);

        // full failure pattern, 30 edges
        do_reset();
        failure = 1'b1; tick = 1'b1; cyc(); {failure, tick} = 2'b00;
        chk4("fail.start", 1'b1, 8'd159, 1'b1, 2'd3);
        for (int k = 1; k <= 30; k++) begin
            int ep;
            frame();
            ep = (k < 6) ? 159 : (k < 12) ? 190 : (k < 18) ? 213 : 239;
            chk($sformatf("fail.per%0d", k), 32'(per1), 32'(ep));
            chk($sformatf("fail.busy%0d", k), 32'(busy1), (k < 30) ? 32'd1 : 32'd0);
        end
        chk("fail.end_en", 32'(en1), 32'd0);

        // success with a dropped eat, then preempted by failure
        do_reset();
        pulse(2);
        repeat (8) frame();
        chk4("succ.step2", 1'b1, 8'd159, 1'b1, 2'd2);
        pulse(1);
        chk4("succ.eat_drop", 1'b1, 8'd159, 1'b1, 2'd2);
        repeat (4) frame();
        chk4("succ.step3", 1'b1, 8'd119, 1'b1, 2'd2);
        pulse(3);
        chk4("succ.preempt", 1'b1, 8'd159, 1'b1, 2'd3);
        repeat (6) frame();
        chk4("succ.fail_step1", 1'b1, 8'd190, 1'b1, 2'd3);

        // async reset mid-failure, then a lone vsync edge
        do_reset();
        pulse(3);
        repeat (6) frame();
        chk4("rst.pre", 1'b1, 8'd190, 1'b1, 2'd3);
        #2 rst_n = 1'b0;
        #1 chk4("rst.async", 1'b0, 8'd0, 1'b0, 2'd0);
        m_reset();
        cyc(); cyc();
        rst_n = 1'b1;
        frame();
        chk4("rst.idle_edge", 1'b0, 8'd0, 1'b0, 2'd0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) vsync = ~vsync;
            failure = ($urandom_range(0, 199) < 1);
            success = ($urandom_range(0, 199) < 2);
            eat     = ($urandom_range(0, 199) < 2);
            tick    = ($urandom_range(0, 199) < 3);
            if ($urandom_range(0, 49) == 0) mute = ~mute;
            cyc();
            chk("rand.en", 32'(en1), 32'(m_en));
            chk("rand.period", 32'(per1), 32'(m_period));
            chk("rand.busy", 32'(busy1), 32'(m_busy));
            chk("rand.sfx", 32'(sfx1), 32'(m_sfx));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
